// File: rtl/game_round_sequencer.sv
// Round controller for the symbol-counting game: countdown, symbol display,
// answer entry and result phases paced by tick1Hz, with grading and level advance.
module game_round_sequencer #(
    parameter int unsigned PRELIM_SECS = 3,
    parameter int unsigned GAME_SECS   = 10,
    parameter int unsigned ANSWER_SECS = 5,
    parameter int unsigned POST_SECS   = 2,
    parameter int unsigned MAX_ERR     = 0,
    parameter int unsigned MAX_LEVEL   = 31
) (
    input  logic       Clk100M,
    input  logic       reset,
    input  logic       start,
    input  logic       tick1Hz,
    input  logic       symTick,
    input  logic [6:0] userCount,
    input  logic [6:0] gameCount,
    output logic       prelimPeriod,
    output logic       gamePeriod,
    output logic       answerPeriod,
    output logic       postPeriod,
    output logic [3:0] countDownTime,
    output logic [4:0] level,
    output logic       levelChng,
    output logic       symReq,
    output logic [6:0] countDifference,
    output logic       loss
);
    typedef enum logic [2:0] {IDLE, PRELIM, GAME, ANSWER, POST, LOST} stateT;

    localparam logic [3:0] PRELIM_LD = 4'(PRELIM_SECS);
    localparam logic [3:0] GAME_LD   = 4'(GAME_SECS);
    localparam logic [3:0] ANSWER_LD = 4'(ANSWER_SECS);
    localparam logic [3:0] POST_LD   = 4'(POST_SECS);
    localparam logic [6:0] ERR_MAX   = 7'(MAX_ERR);
    localparam logic [4:0] LVL_MAX   = 5'(MAX_LEVEL);

    stateT      state;
    logic       pass;
    logic [6:0] absDiff;
    logic       expire;

    assign absDiff = (userCount >= gameCount) ? (userCount - gameCount) : (gameCount - userCount);
    assign expire  = tick1Hz && (countDownTime == 4'd1);

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            level           <= 5'd1;
            countDownTime   <= 4'd0;
            countDifference <= 7'd0;
            pass            <= 1'b0;
            prelimPeriod    <= 1'b0;
            gamePeriod      <= 1'b0;
            answerPeriod    <= 1'b0;
            postPeriod      <= 1'b0;
            loss            <= 1'b0;
            symReq          <= 1'b0;
            levelChng       <= 1'b0;
        end else begin
            levelChng <= 1'b0;
            symReq    <= 1'b0;
            case (state)
                IDLE, LOST: begin
                    if (start) begin
                        state         <= PRELIM;
                        level         <= 5'd1;
                        loss          <= 1'b0;
                        countDownTime <= PRELIM_LD;
                        prelimPeriod  <= 1'b1;
                    end
                end
                PRELIM: begin
                    if (expire) begin
                        state         <= GAME;
                        countDownTime <= GAME_LD;
                        prelimPeriod  <= 1'b0;
                        gamePeriod    <= 1'b1;
                    end else if (tick1Hz) begin
                        countDownTime <= countDownTime - 4'd1;
                    end
                end
                GAME: begin
                    // a symTick on the exit cycle would land in ANSWER, so drop it
                    symReq <= symTick && !expire;
                    if (expire) begin
                        state         <= ANSWER;
                        countDownTime <= ANSWER_LD;
                        gamePeriod    <= 1'b0;
                        answerPeriod  <= 1'b1;
                    end else if (tick1Hz) begin
                        countDownTime <= countDownTime - 4'd1;
                    end
                end
                ANSWER: begin
                    if (expire) begin
                        state           <= POST;
                        countDownTime   <= POST_LD;
                        countDifference <= absDiff;
                        pass            <= (absDiff <= ERR_MAX);
                        answerPeriod    <= 1'b0;
                        postPeriod      <= 1'b1;
                    end else if (tick1Hz) begin
                        countDownTime <= countDownTime - 4'd1;
                    end
                end
                POST: begin
                    if (expire) begin
                        postPeriod <= 1'b0;
                        if (pass) begin
                            state         <= PRELIM;
                            countDownTime <= PRELIM_LD;
                            prelimPeriod  <= 1'b1;
                            if (level < LVL_MAX) begin
                                level     <= level + 5'd1;
                                levelChng <= 1'b1;
                            end
                        end else begin
                            state         <= LOST;
                            countDownTime <= 4'd0;
                            loss          <= 1'b1;
                        end
                    end else if (tick1Hz) begin
                        countDownTime <= countDownTime - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
